// File: rtl/clock_weekday_segment_decoder.sv
// Serial 40-bit segment-frame receiver that decodes three display letters into a
// weekday code and holds the result behind a valid/ready handshake.
module clock_weekday_segment_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin_data,
  input  logic       sin_valid,
  input  logic       sin_first,
  output logic [2:0] day_code,
  output logic       day_valid,
  input  logic       day_ready,
  output logic       day_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE, HOLD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [39:0] sreg;
  logic [5:0]  count;
  logic        take_first;
  logic        take_bit;

  // Returns {err, code}; frame layout is letter I (20b), II (10b), III (10b).
  function automatic logic [3:0] decode_frame(input logic [39:0] f);
    logic [3:0] r;
    case (f)
      {20'b11001000010000010111, 10'b1111100000, 10'b1001110101}: r = 4'b0000;
      {20'b00101000000110110000, 10'b0000000000, 10'b0000000000}: r = 4'b0001;
      {20'b11000001000001000000, 10'b0000000000, 10'b0000000000}: r = 4'b0010;
      {20'b00010110110000001000, 10'b0000000000, 10'b0000000000}: r = 4'b0011;
      {20'b11000001000001000000, 10'b1110100001, 10'b0000000000}: r = 4'b0100;
      {20'b11000000000100010110, 10'b0000000000, 10'b0000000000}: r = 4'b0101;
      {20'b11001000010000010111, 10'b0000011111, 10'b0110001010}: r = 4'b0110;
      default:                                                    r = 4'b1111;
    endcase
    return r;
  endfunction

  // A first-flagged bit restarts the frame from IDLE or mid-SHIFT only.
  assign take_first = sin_valid && sin_first && (state == IDLE || state == SHIFT);
  assign take_bit   = sin_valid && !sin_first && (state == SHIFT);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take_first) state_nxt = SHIFT;
      SHIFT:   if (take_bit && count == 6'd39) state_nxt = DECODE;
      DECODE:  state_nxt = HOLD;
      HOLD:    if (day_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      count     <= '0;
      day_code  <= '0;
      day_valid <= 1'b0;
      day_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= sin_valid && (state == DECODE || state == HOLD);
      if (take_first) begin
        sreg  <= {39'b0, sin_data};
        count <= 6'd1;
      end else if (take_bit) begin
        sreg  <= {sreg[38:0], sin_data};
        count <= count + 6'd1;
      end
      // Result registers load in DECODE and stay frozen through HOLD.
      if (state == DECODE) begin
        {day_err, day_code} <= decode_frame(sreg);
        day_valid           <= 1'b1;
      end else if (state == HOLD && day_ready) begin
        day_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_weekday_segment_decoder.sv
// Bench for clock_weekday_segment_decoder: directed and randomized frames checked
// against a table-lookup reference of the weekday patterns.
module tb_clock_weekday_segment_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin_data;
  logic       sin_valid;
  logic       sin_first;
  logic       day_ready;
  logic [2:0] day_code;
  logic       day_valid;
  logic       day_err;
  logic       overrun;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic [19:0] tab_i   [7];
  logic [9:0]  tab_ii  [7];
  logic [9:0]  tab_iii [7];

  always #5 clk = ~clk;

  clock_weekday_segment_decoder dut (
    .clk(clk), .rst(rst), .sin_data(sin_data), .sin_valid(sin_valid),
    .sin_first(sin_first), .day_code(day_code), .day_valid(day_valid),
    .day_ready(day_ready), .day_err(day_err), .overrun(overrun), .busy(busy)
  );

  function automatic logic [39:0] frame_of(input int d);
    return {tab_i[d], tab_ii[d], tab_iii[d]};
  endfunction

  // Reference: search the weekday table; no match means code 7 with error.
  function automatic logic [3:0] ref_decode(input logic [39:0] f);
    for (int d = 0; d < 7; d++)
      if (f == frame_of(d)) return {1'b0, 3'(d)};
    return 4'b1111;
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_code"}, 40'(day_code), 40'd0);
    chk({tag, "_dv"}, 40'(day_valid), 40'd0);
    chk({tag, "_err"}, 40'(day_err), 40'd0);
    chk({tag, "_ovr"}, 40'(overrun), 40'd0);
    chk({tag, "_busy"}, 40'(busy), 40'd0);
  endtask

  task automatic send_bits(input logic [39:0] f, input int nbits, input int gap_pct);
    for (int i = 0; i < nbits; i++) begin
      for (int g = 0; g < 8 && int'($urandom_range(99)) < gap_pct; g++) begin
        sin_valid = 1'b0;
        tick();
        if (i > 0) chk("busy_gap", 40'(busy), 40'd1);
      end
      sin_valid = 1'b1;
      sin_first = (i == 0);
      sin_data  = f[39-i];
      tick();
    end
    sin_valid = 1'b0;
    sin_first = 1'b0;
  endtask

  // Called right after the 40th bit was accepted: DECODE now, HOLD one edge later.
  task automatic expect_result(input logic [39:0] f, output logic [3:0] r);
    r = ref_decode(f);
    chk("dv_in_decode", 40'(day_valid), 40'd0);
    chk("busy_in_decode", 40'(busy), 40'd1);
    tick();
    chk("dv_hold", 40'(day_valid), 40'd1);
    chk("code", 40'(day_code), 40'(r[2:0]));
    chk("err", 40'(day_err), 40'(r[3]));
  endtask

  task automatic release_result(input int hold, input logic [3:0] r);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("dv_stable", 40'(day_valid), 40'd1);
      chk("code_stable", {36'd0, day_err, day_code}, 40'(r));
    end
    day_ready = 1'b1;
    tick();
    day_ready = 1'b0;
    chk("dv_after_accept", 40'(day_valid), 40'd0);
    chk("busy_after_accept", 40'(busy), 40'd0);
  endtask

  task automatic run_frame(input logic [39:0] f, input int gap_pct, input int hold);
    logic [3:0] r;
    send_bits(f, 40, gap_pct);
    expect_result(f, r);
    release_result(hold, r);
  endtask

  initial begin
    logic [3:0]  r;
    logic [39:0] f;
    logic [63:0] rnd;

    tab_i[0] = 20'b11001000010000010111; tab_ii[0] = 10'b1111100000; tab_iii[0] = 10'b1001110101;
    tab_i[1] = 20'b00101000000110110000; tab_ii[1] = 10'b0;          tab_iii[1] = 10'b0;
    tab_i[2] = 20'b11000001000001000000; tab_ii[2] = 10'b0;          tab_iii[2] = 10'b0;
    tab_i[3] = 20'b00010110110000001000; tab_ii[3] = 10'b0;          tab_iii[3] = 10'b0;
    tab_i[4] = 20'b11000001000001000000; tab_ii[4] = 10'b1110100001; tab_iii[4] = 10'b0;
    tab_i[5] = 20'b11000000000100010110; tab_ii[5] = 10'b0;          tab_iii[5] = 10'b0;
    tab_i[6] = 20'b11001000010000010111; tab_ii[6] = 10'b0000011111; tab_iii[6] = 10'b0110001010;

    rst = 1'b1; sin_data = 1'b0; sin_valid = 1'b0; sin_first = 1'b0; day_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_init");
    rst = 1'b0;

    // Bits without a first flag must not open a frame.
    for (int k = 0; k < 3; k++) begin
      sin_valid = 1'b1; sin_first = 1'b0; sin_data = 1'($urandom);
      tick();
      chk("idle_ignore_busy", 40'(busy), 40'd0);
    end
    sin_valid = 1'b0;

    run_frame(frame_of(0), 0, 0);
    run_frame(frame_of(4), 0, 5);
    run_frame(frame_of(2), 0, 5);
    run_frame({tab_i[0], tab_ii[6], tab_iii[0]}, 0, 0);

    rnd = {$urandom, $urandom};
    send_bits(rnd[39:0], 17, 0);
    run_frame(frame_of(5), 0, 0);

    // Bits arriving in DECODE and HOLD are dropped and flagged.
    f = frame_of(1);
    send_bits(f, 40, 0);
    sin_valid = 1'b1; sin_first = 1'b0; sin_data = 1'b1;
    expect_result(f, r);
    chk("ovr_decode", 40'(overrun), 40'd1);
    sin_first = 1'b1;
    tick();
    chk("ovr_hold", 40'(overrun), 40'd1);
    chk("hold_unaffected", {36'd0, day_err, day_code}, 40'(r));
    sin_valid = 1'b0; sin_first = 1'b0;
    tick();
    chk("ovr_clear", 40'(overrun), 40'd0);
    release_result(0, r);
    run_frame(frame_of(3), 0, 0);

    // Async reset mid-frame, then in HOLD.
    send_bits(frame_of(2), 25, 0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_midframe");
    tick();
    rst = 1'b0;
    run_frame(frame_of(3), 0, 0);

    f = frame_of(6);
    send_bits(f, 40, 0);
    expect_result(f, r);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_hold");
    tick();
    rst = 1'b0;
    tick();
    chk("busy_after_rst", 40'(busy), 40'd0);
    run_frame(frame_of(3), 0, 0);

    for (int d = 0; d < 7; d++) run_frame(frame_of(d), 50, int'($urandom_range(3)));

    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(1) == 1) begin
        f = frame_of(int'($urandom_range(6)));
        if ($urandom_range(2) == 0) f[$urandom_range(39)] ^= 1'b1;
      end else begin
        rnd = {$urandom, $urandom};
        f = rnd[39:0];
      end
      run_frame(f, 25, int'($urandom_range(2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000ns");
    $fatal(1);
  end

endmodule
